// File: rtl/exec_trace_monitor_pkg.sv
// Shared opcode map, instruction classes and record layout for the execution
// trace monitor.
package exec_trace_monitor_pkg;

  localparam int REC_W = 46;  // {pc[7:0], opcode[5:0], result[31:0]}

  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02,
                         OP_OR   = 6'h03, OP_XOR  = 6'h04, OP_NOR  = 6'h05,
                         OP_SLT  = 6'h06, OP_SLL  = 6'h07, OP_SRL  = 6'h08,
                         OP_SRA  = 6'h09, OP_ADDI = 6'h0A, OP_LW   = 6'h0B,
                         OP_LH   = 6'h0C, OP_LB   = 6'h0D, OP_LUI  = 6'h0E,
                         OP_ORI  = 6'h0F, OP_SW   = 6'h10, OP_SH   = 6'h11,
                         OP_SB   = 6'h12, OP_BEQ  = 6'h13, OP_BNE  = 6'h14,
                         OP_BLT  = 6'h15, OP_J    = 6'h16, OP_JAL  = 6'h17,
                         OP_JR   = 6'h18;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } cls_e;

  // 0x0E/0x0F are immediate ALU ops sitting just above the loads.
  function automatic cls_e classify(input logic [5:0] op);
    if (op <= OP_ADDI || op == OP_LUI || op == OP_ORI) return CLS_ALU;
    else if (op <= OP_LB)  return CLS_LOAD;
    else if (op <= OP_SB)  return CLS_STORE;
    else if (op <= OP_BLT) return CLS_BRANCH;
    else if (op <= OP_JR)  return CLS_JUMP;
    else                   return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/exec_trace_monitor_trace_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clr && !reset) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/exec_trace_monitor.sv
// Observer for the single-cycle datapath: classifies retired instructions,
// counts them, detects taken branches and halt, and buffers a trace FIFO.
module exec_trace_monitor
  import exec_trace_monitor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int PC_STEP     = 1,
  parameter int HALT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [7:0]       pc,
  input  logic [5:0]       opcode,
  input  logic [31:0]      result,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_pc,
  output logic [5:0]       rd_opcode,
  output logic [31:0]      rd_result,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_jump,
  output logic [CNT_W-1:0] cnt_illegal,
  output logic [CNT_W-1:0] cnt_drop,
  output logic             halted,
  output logic             overflow
);
  localparam int NCNT = 9;
  localparam int I_TOT = 0, I_ALU = 1, I_LD = 2, I_ST = 3, I_BR = 4,
                 I_TKN = 5, I_JMP = 6, I_ILL = 7, I_DROP = 8;
  localparam int SW = $clog2(HALT_CYCLES + 1);

  logic [NCNT-1:0][CNT_W-1:0] cnt_q;
  logic [NCNT-1:0]            inc;
  logic [7:0]                 prev_pc_q, bpc_q;
  logic [SW-1:0]              stuck_q, stuck_d;
  logic                       pend_q, halted_q, ovf_q;
  logic                       sample, full, empty, pop, drop, is_br;
  logic [REC_W-1:0]           head;
  cls_e                       cls;

  assign sample = en && !clr && !halted_q;
  assign cls    = classify(opcode);
  assign is_br  = (cls == CLS_BRANCH);
  assign pop    = rd_ready && !empty;
  assign drop   = sample && full && !pop;
  // stuck_q == 0 marks "no sample since reset/clr", so the first one starts at 1.
  assign stuck_d = (stuck_q != '0 && pc == prev_pc_q) ? stuck_q + 1'b1 : SW'(1);

  always_comb begin
    inc = '0;
    if (sample) begin
      inc[I_TOT] = 1'b1;
      case (cls)
        CLS_ALU:    inc[I_ALU] = 1'b1;
        CLS_LOAD:   inc[I_LD]  = 1'b1;
        CLS_STORE:  inc[I_ST]  = 1'b1;
        CLS_BRANCH: inc[I_BR]  = 1'b1;
        CLS_JUMP:   inc[I_JMP] = 1'b1;
        default:    inc[I_ILL] = 1'b1;
      endcase
      if (pend_q && pc != 8'(bpc_q + 8'(PC_STEP))) inc[I_TKN] = 1'b1;
      inc[I_DROP] = drop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      prev_pc_q <= '0;
      bpc_q     <= '0;
      stuck_q   <= '0;
      pend_q    <= 1'b0;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clr) begin
      cnt_q     <= '0;
      prev_pc_q <= '0;
      bpc_q     <= '0;
      stuck_q   <= '0;
      pend_q    <= 1'b0;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (sample) begin
      for (int i = 0; i < NCNT; i++)
        if (inc[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      prev_pc_q <= pc;
      stuck_q   <= stuck_d;
      pend_q    <= is_br;
      if (is_br) bpc_q <= pc;
      if (stuck_d == SW'(HALT_CYCLES)) halted_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .push_i  (sample),
    .data_i  ({pc, opcode, result}),
    .pop_i   (rd_ready),
    .full_o  (full),
    .empty_o (empty),
    .data_o  (head)
  );

  assign rd_valid                       = !empty;
  assign {rd_pc, rd_opcode, rd_result}  = head;
  assign cnt_total   = cnt_q[I_TOT];
  assign cnt_alu     = cnt_q[I_ALU];
  assign cnt_load    = cnt_q[I_LD];
  assign cnt_store   = cnt_q[I_ST];
  assign cnt_branch  = cnt_q[I_BR];
  assign cnt_taken   = cnt_q[I_TKN];
  assign cnt_jump    = cnt_q[I_JMP];
  assign cnt_illegal = cnt_q[I_ILL];
  assign cnt_drop    = cnt_q[I_DROP];
  assign halted      = halted_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/exec_trace_monitor.md
Name: exec_trace_monitor

Overview:
- Downstream observer stage for the single-cycle datapath; consumes its per-cycle pc, opcode and result outputs.
- Classifies each retired instruction and keeps saturating per-class counters.
- Detects taken branches and program halt (PC stuck).
- Buffers (pc, opcode, result) records in a FIFO, drained over a valid/ready read port. This replaces printing from a bench with a synthesizable trace.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- CNT_W, 16, width of every counter
- PC_STEP, 1, sequential PC increment, modulo 256
- HALT_CYCLES, 3, consecutive samples with an unchanged pc that declare halt (≥2)

Ports:
- clk  in  1  rising-edge clock, same clock as datapath
- reset  in  1  asynchronous, active-high reset
- en  in  1  sample enable; a cycle counts only when en=1
- clr  in  1  synchronous clear of counters, flags and FIFO; has priority over all other synchronous activity
- pc  in  8  datapath PC
- opcode  in  6  datapath opcode
- result  in  32  datapath result
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  consumer accepts head
- rd_pc  out  8  head record pc
- rd_opcode  out  6  head record opcode
- rd_result  out  32  head record result
- cnt_total, cnt_alu, cnt_load, cnt_store, cnt_branch, cnt_taken, cnt_jump, cnt_illegal, cnt_drop  out  CNT_W each  counters
- halted  out  1  sticky halt flag
- overflow  out  1  sticky FIFO-drop flag

Behaviour:
- Reset (async, immediate, including mid-operation):
  - All counters = 0; halted = 0; overflow = 0.
  - FIFO empty; rd_valid = 0.
  - rd_pc, rd_opcode and rd_result = 0.
  - Internal prev_pc = 0, stuck count = 0, branch pending = 0.
- Sample: a rising edge with en=1, clr=0 and halted=0. No sampling occurs while halted; only reset or clr leave the halted state.
- Classification of opcode per sample:
  - ALU: 0x00–0x0A, 0x0E, 0x0F.
  - Load: 0x0B–0x0D.
  - Store: 0x10–0x12.
  - Branch: 0x13–0x15.
  - Jump: 0x16–0x18.
  - Illegal: 0x19–0x3F.
- Counting: cnt_total and exactly one class counter increment per sample. All counters saturate at 2^CNT_W−1 and do not wrap.
- Taken branch:
  - A branch sample sets pending and latches its pc.
  - On the next sample, if pc ≠ (latched_pc + PC_STEP) mod 256, cnt_taken increments. Pending then clears.
  - Gaps with en=0 are allowed; resolution waits for the next sample.
  - A branch sample that resolves a pending branch also sets a new pending.
- Halt detection:
  - Per sample, if pc == prev_pc, the stuck count increments; otherwise it resets to 1. prev_pc updates on every sample.
  - When the stuck count reaches HALT_CYCLES, halted = 1 on that edge. The halting sample itself is still counted and pushed.
  - The first sample after reset/clr starts the stuck count at 1.
- FIFO:
  - Each sample pushes {pc, opcode, result}.
  - Show-ahead read: rd_* reflect the head combinationally while rd_valid = 1. While empty, rd_* = 0.
  - Pop occurs when rd_valid && rd_ready.
  - Push with the FIFO full and no pop: the record is dropped, overflow is set (sticky) and cnt_drop increments. Class counters still count the dropped sample.
  - Push with the FIFO full and a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Push and pop on an empty FIFO: no pop (rd_valid = 0); the push is accepted.
  - Pointers wrap modulo DEPTH. Occupancy uses a DEPTH+1 range (extra bit).
- clr: same end state as reset, applied on the edge. A sample or push in the same cycle is discarded.
- Latency:
  - Counters and flags are visible one cycle after the sampling edge.
  - A pushed record is visible on rd_* one cycle after its push edge.

Decomposition:
- Shared package:
  - 6-bit opcode constants for all 25 opcodes (OP_ADD … OP_JR).
  - Class enum: CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL.
  - Classify function.
  - Record width constant (46).
- Sub-module: trace_fifo, a parameterised synchronous FIFO (DEPTH, WIDTH) with push/full/pop/empty and show-ahead data, sharing clk/reset/clr.

Test Plan:
- Reset mid-stream: after 5 samples, pulse reset asynchronously between edges → all counters and flags read 0, rd_valid = 0 and rd_* = 0 immediately, before the next edge.
- Classification: feed opcodes 0x00, 0x0D, 0x12, 0x16, 0x2A at pc 0,1,2,3,4 with rd_ready = 0 → cnt_total=5; alu=load=store=jump=illegal=1; FIFO holds 5 records. Drain yields pc 0..4 in order with matching opcode/result.
- Taken branch:
  - opcode 0x13 at pc=10, then pc=11 → cnt_taken=0.
  - opcode 0x14 at pc=20, then pc=30 → cnt_taken=1.
  - Branch at pc=255, next pc=0 with PC_STEP=1 → not taken.
- Halt: pc sequence 5,6,7,7,7,8 → halted=1 on the fifth sample; cnt_total=5; the sixth sample (pc 8) is ignored. clr then restores halted=0 and counters=0.
- Overflow: DEPTH=16, rd_ready=0, 18 samples → 16 stored, cnt_drop=2, overflow=1, cnt_total=18.
- Full with simultaneous pop: FIFO full, rd_ready=1 with one sample → the record is accepted, occupancy stays 16, cnt_drop unchanged, and the new record appears last on drain.
